// File: rtl/ctr_m_pkg.sv
// ctr_m_pkg: shared M-stage codes, opcode/funct constants and the decoded-instruction record.
package ctr_m_pkg;
    localparam logic [1:0] T_ALU = 2'b01;
    localparam logic [1:0] T_DM  = 2'b10;
    localparam logic [1:0] T_PC  = 2'b00;
    localparam logic [4:0] RA_IDX = 5'd31;
    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_DM  = 2'b01,
        WD_PC8 = 2'b10
    } wdsel_e;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
    } instr_t;
    // Tnew counts down one per stage and never goes below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == T_PC) ? T_PC : t - 2'd1;
    endfunction
endpackage

// File: rtl/ctr_m_if.sv
// ctr_m_if: E-to-M instruction fields, W feedback and the M-stage control outputs.
interface ctr_m_if;
    logic [5:0] op_23;
    logic [5:0] func_23;
    logic [4:0] rt_23;
    logic [4:0] rd_23;
    logic       RegWr_E;
    logic [1:0] Tnew_E;
    logic [4:0] A3_W;
    logic       RegWr_W;
    logic [5:0] op_34;
    logic [5:0] func_34;
    logic [4:0] rt_34;
    logic [4:0] A3_M;
    logic       RegWr_M;
    logic       MemWr;
    logic [1:0] WDsel_M;
    logic [1:0] Tnew_M;
    logic       MF_WD_M;
    modport master (
        output op_23, func_23, rt_23, rd_23, RegWr_E, Tnew_E, A3_W, RegWr_W,
        input  op_34, func_34, rt_34, A3_M, RegWr_M, MemWr, WDsel_M, Tnew_M, MF_WD_M
    );
    modport slave (
        input  op_23, func_23, rt_23, rd_23, RegWr_E, Tnew_E, A3_W, RegWr_W,
        output op_34, func_34, rt_34, A3_M, RegWr_M, MemWr, WDsel_M, Tnew_M, MF_WD_M
    );
endinterface

// File: rtl/ctr_m_dec.sv
// ctr_m_dec: opcode/funct to one-hot instruction flags.
module ctr_m_dec
    import ctr_m_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     ins
);
    logic r_type;
    assign r_type   = (op == OP_RTYPE);
    assign ins.addu = r_type && (func == FN_ADDU);
    assign ins.subu = r_type && (func == FN_SUBU);
    assign ins.jr   = r_type && (func == FN_JR);
    assign ins.ori  = (op == OP_ORI);
    assign ins.lui  = (op == OP_LUI);
    assign ins.lw   = (op == OP_LW);
    assign ins.sw   = (op == OP_SW);
    assign ins.beq  = (op == OP_BEQ);
    assign ins.j    = (op == OP_J);
    assign ins.jal  = (op == OP_JAL);
endmodule

// File: rtl/ctr_m.sv
// ctr_m: M-stage control; registers the E instruction and derives DM, write-back and hazard controls.
module ctr_m
    import ctr_m_pkg::*;
(
    input logic   clk,
    input logic   reset,
    ctr_m_if.slave bus
);
    logic [5:0] op_r;
    logic [5:0] func_r;
    logic [4:0] rt_r;
    logic [4:0] rd_r;
    logic       regwr_r;
    logic [1:0] tnew_r;
    instr_t     ins;
    logic       is_ctrl;
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= '0;
            func_r  <= '0;
            rt_r    <= '0;
            rd_r    <= '0;
            regwr_r <= 1'b0;
            tnew_r  <= '0;
        end else begin
            op_r    <= bus.op_23;
            func_r  <= bus.func_23;
            rt_r    <= bus.rt_23;
            rd_r    <= bus.rd_23;
            regwr_r <= bus.RegWr_E;
            tnew_r  <= bus.Tnew_E;
        end
    end
    ctr_m_dec u_dec (
        .op   (op_r),
        .func (func_r),
        .ins  (ins)
    );
    // Control transfers other than jal have no destination register.
    assign is_ctrl = ins.beq | ins.j | ins.jr;
    assign bus.op_34   = op_r;
    assign bus.func_34 = func_r;
    assign bus.rt_34   = rt_r;
    assign bus.A3_M    = is_ctrl                        ? 5'd0 :
                         (ins.addu | ins.subu)          ? rd_r :
                         (ins.ori | ins.lui | ins.lw)   ? rt_r :
                         ins.jal                        ? RA_IDX : 5'd0;
    assign bus.RegWr_M = regwr_r && (bus.A3_M != 5'd0);
    assign bus.MemWr   = ins.sw;
    assign bus.WDsel_M = ins.lw ? WD_DM : ins.jal ? WD_PC8 : WD_ALU;
    assign bus.Tnew_M  = tnew_dec(tnew_r);
    assign bus.MF_WD_M = ins.sw && bus.RegWr_W && (bus.A3_W == rt_r) && (bus.A3_W != 5'd0);
endmodule

// File: tb/tb_ctr_m.sv
// tb_ctr_m: directed vector table plus reset sequences for the M-stage controller.
module tb_ctr_m;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    ctr_m_if bus ();
    ctr_m dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regwr;
        logic [1:0] tnew;
        logic [4:0] a3w;
        logic       regww;
        logic [4:0] e_a3;
        logic       e_rw;
        logic       e_mw;
        logic [1:0] e_wd;
        logic [1:0] e_tn;
        logic       e_mf;
    } vec_t;
    vec_t vt[$];
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rt,
                         input logic [4:0] rd, input logic regwr, input logic [1:0] tnew,
                         input logic [4:0] a3w, input logic regww);
        bus.op_23 = op;
        bus.func_23 = func;
        bus.rt_23 = rt;
        bus.rd_23 = rd;
        bus.RegWr_E = regwr;
        bus.Tnew_E = tnew;
        bus.A3_W = a3w;
        bus.RegWr_W = regww;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".op"}, {2'b0, bus.op_34}, 8'h00);
        chk({tag, ".func"}, {2'b0, bus.func_34}, 8'h00);
        chk({tag, ".rt"}, {3'b0, bus.rt_34}, 8'h00);
        chk({tag, ".a3"}, {3'b0, bus.A3_M}, 8'h00);
        chk({tag, ".rw"}, {7'b0, bus.RegWr_M}, 8'h00);
        chk({tag, ".mw"}, {7'b0, bus.MemWr}, 8'h00);
        chk({tag, ".wd"}, {6'b0, bus.WDsel_M}, 8'h00);
        chk({tag, ".tn"}, {6'b0, bus.Tnew_M}, 8'h00);
        chk({tag, ".mf"}, {7'b0, bus.MF_WD_M}, 8'h00);
    endtask
    initial begin
        //        name      op     func   rt  rd  rw tn     a3w rww  a3  rw mw wd     tn     mf
        vt.push_back('{"addu",  6'h00, 6'h21, 3,  8,  1, 2'b01, 0,  0,  8,  1, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"subu",  6'h00, 6'h23, 4,  9,  1, 2'b01, 0,  0,  9,  1, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"jal",   6'h03, 6'h00, 0,  0,  1, 2'b00, 0,  0,  31, 1, 0, 2'b10, 2'b00, 0});
        vt.push_back('{"sw_fw", 6'h2b, 6'h00, 5,  0,  0, 2'b00, 5,  1,  0,  0, 1, 2'b00, 2'b00, 1});
        vt.push_back('{"sw_a6", 6'h2b, 6'h00, 5,  0,  0, 2'b00, 6,  1,  0,  0, 1, 2'b00, 2'b00, 0});
        vt.push_back('{"sw_r0", 6'h2b, 6'h00, 0,  0,  0, 2'b00, 0,  1,  0,  0, 1, 2'b00, 2'b00, 0});
        vt.push_back('{"sw_nw", 6'h2b, 6'h00, 5,  0,  0, 2'b00, 5,  0,  0,  0, 1, 2'b00, 2'b00, 0});
        vt.push_back('{"ori0",  6'h0d, 6'h00, 0,  0,  1, 2'b01, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"ori7",  6'h0d, 6'h00, 7,  2,  1, 2'b01, 7,  1,  7,  1, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"lui",   6'h0f, 6'h00, 10, 1,  1, 2'b01, 0,  0,  10, 1, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"lw",    6'h23, 6'h00, 12, 3,  1, 2'b10, 0,  0,  12, 1, 0, 2'b01, 2'b01, 0});
        vt.push_back('{"sw",    6'h2b, 6'h00, 2,  0,  0, 2'b00, 12, 1,  0,  0, 1, 2'b00, 2'b00, 0});
        vt.push_back('{"beq",   6'h04, 6'h00, 6,  4,  0, 2'b00, 6,  1,  0,  0, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"j",     6'h02, 6'h00, 0,  0,  0, 2'b00, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"jr",    6'h00, 6'h08, 0,  0,  0, 2'b00, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"tn11",  6'h00, 6'h21, 1,  3,  1, 2'b11, 0,  0,  3,  1, 0, 2'b00, 2'b10, 0});
        vt.push_back('{"beq_rw",6'h04, 6'h00, 9,  9,  1, 2'b01, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0});
        vt.push_back('{"lw_fn", 6'h23, 6'h21, 17, 4,  1, 2'b10, 0,  0,  17, 1, 0, 2'b01, 2'b01, 0});
        vt.push_back('{"nop",   6'h00, 6'h00, 8,  8,  1, 2'b01, 8,  1,  0,  0, 0, 2'b00, 2'b00, 0});
        // Reset held two cycles with lw presented, then released.
        drive(6'h23, 6'h00, 5'd14, 5'd2, 1'b1, 2'b10, 5'd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_lw.a3", {3'b0, bus.A3_M}, 8'd14);
        chk("rst_lw.wd", {6'b0, bus.WDsel_M}, 8'd1);
        chk("rst_lw.tn", {6'b0, bus.Tnew_M}, 8'd1);
        chk("rst_lw.rw", {7'b0, bus.RegWr_M}, 8'd1);
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].func, vt[i].rt, vt[i].rd, vt[i].regwr, vt[i].tnew, vt[i].a3w, vt[i].regww);
            @(posedge clk);
            #1;
            chk({vt[i].name, ".op"}, {2'b0, bus.op_34}, {2'b0, vt[i].op});
            chk({vt[i].name, ".func"}, {2'b0, bus.func_34}, {2'b0, vt[i].func});
            chk({vt[i].name, ".rt"}, {3'b0, bus.rt_34}, {3'b0, vt[i].rt});
            chk({vt[i].name, ".a3"}, {3'b0, bus.A3_M}, {3'b0, vt[i].e_a3});
            chk({vt[i].name, ".rw"}, {7'b0, bus.RegWr_M}, {7'b0, vt[i].e_rw});
            chk({vt[i].name, ".mw"}, {7'b0, bus.MemWr}, {7'b0, vt[i].e_mw});
            chk({vt[i].name, ".wd"}, {6'b0, bus.WDsel_M}, {6'b0, vt[i].e_wd});
            chk({vt[i].name, ".tn"}, {6'b0, bus.Tnew_M}, {6'b0, vt[i].e_tn});
            chk({vt[i].name, ".mf"}, {7'b0, bus.MF_WD_M}, {7'b0, vt[i].e_mf});
        end
        // Reset mid-stream squashes M, then the next cycle loads normally.
        @(negedge clk);
        drive(6'h00, 6'h21, 5'd1, 5'd20, 1'b1, 2'b01, 5'd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_zero("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.a3", {3'b0, bus.A3_M}, 8'd20);
        chk("post_rst.rw", {7'b0, bus.RegWr_M}, 8'd1);
        // Forwarding select follows A3_W/RegWr_W combinationally within the cycle.
        @(negedge clk);
        drive(6'h2b, 6'h00, 5'd9, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0);
        @(posedge clk);
        #1 chk("sw_comb0.mf", {7'b0, bus.MF_WD_M}, 8'd0);
        bus.A3_W = 5'd9;
        bus.RegWr_W = 1'b1;
        #1 chk("sw_comb1.mf", {7'b0, bus.MF_WD_M}, 8'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
